// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and types for the seven-segment capture block
//
// Contents:
//   SEG_0..SEG_F  7-bit active-low segment patterns, bit order {a,b,c,d,e,f,g}
//   ANODE_BLANK   anode value meaning "no digit driven"
//   state_t       dwell FSM state encoding (SETTLE / HOLD)
//   onehot_low    true when exactly one bit of an active-low vector is asserted
package sevenseg_pkg;

    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    localparam logic [7:0] ANODE_BLANK = 8'hFF;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    function automatic logic onehot_low(input logic [7:0] v);
        logic [7:0] act;
        act = ~v;
        return (act != 8'h00) && ((act & (act - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/segtohex.sv
// rtl/segtohex.sv - combinational decode of an active-low segment pattern to a hex nibble
//
// Ports:
//   seg  in  7  active-low segments {a,b,c,d,e,f,g}
//   hex  out 4  decoded nibble (0 when no match)
//   hit  out 1  seg matched one of the 16 hex glyphs
module segtohex
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       hit
);

    always_comb begin
        hex = 4'h0;
        hit = 1'b1;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - reassembles the 32-bit value shown on a multiplexed 8-digit seven-segment bus
//
// Parameter:
//   STABLE_CYCLES  edges (after the first) a dwell must hold before it is decoded, 1..255
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   anode        in   8   active-low one-hot digit select
//   cathode      in   8   active-low segments {a,b,c,d,e,f,g,dp}
//   digit        out  4   last decoded nibble
//   digit_idx    out  3   position of that nibble
//   digit_valid  out  1   pulse: digit/digit_idx updated
//   value        out 32   last complete frame, digit i at value[4i+3:4i]
//   value_valid  out  1   pulse: value updated
//   dp_mask      out  8   decimal points of the last frame (1 = lit)
//   seg_err      out  1   pulse: settled dwell was undecodable or had a bad anode
// Build option:
//   SEVENSEG_CAPTURE_DP_EN  capture decimal points into dp_mask; otherwise dp_mask is 0
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  anode,
    input  logic [7:0]  cathode,
    output logic [3:0]  digit,
    output logic [2:0]  digit_idx,
    output logic        digit_valid,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [7:0]  dp_mask,
    output logic        seg_err
);

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [7:0]  anode_q;
    logic [7:0]  cathode_q;
    logic [7:0]  cnt;
    state_t      state;
    logic [31:0] shadow;
    logic [7:0]  captured;

    logic        changed;
    logic [7:0]  cnt_next;
    logic        eval;
    logic [3:0]  hex;
    logic        hit;
    logic [2:0]  idx;
    logic [7:0]  idx_bit;
    logic        write_en;
    logic        bad;
    logic [7:0]  captured_next;
    logic        frame_done;
    logic [31:0] shadow_next;

    segtohex u_segtohex (
        .seg (cathode_q[7:1]),
        .hex (hex),
        .hit (hit)
    );

    // The incoming pair is compared with the held sample in the same edge,
    // so the evaluation fires on the edge where the count reaches STABLE_N.
    assign changed  = {anode, cathode} != {anode_q, cathode_q};
    assign cnt_next = changed ? 8'd0 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);
    assign eval     = (state == SETTLE) && !changed && (cnt_next == STABLE_N);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anode_q[i]) idx = 3'(i);
        end
    end

    assign idx_bit       = 8'd1 << idx;
    assign bad           = !onehot_low(anode_q) || !hit;
    assign write_en      = eval && (anode_q != ANODE_BLANK) && !bad;
    assign captured_next = captured | idx_bit;
    assign frame_done    = write_en && (captured_next == 8'hFF);

    always_comb begin
        shadow_next = shadow;
        shadow_next[{idx, 2'b00} +: 4] = hex;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_q     <= ANODE_BLANK;
            cathode_q   <= 8'hFF;
            cnt         <= 8'd0;
            state       <= SETTLE;
            shadow      <= 32'd0;
            captured    <= 8'd0;
            digit       <= 4'd0;
            digit_idx   <= 3'd0;
            digit_valid <= 1'b0;
            value       <= 32'd0;
            value_valid <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            anode_q     <= anode;
            cathode_q   <= cathode;
            cnt         <= cnt_next;
            digit_valid <= 1'b0;
            value_valid <= 1'b0;
            seg_err     <= 1'b0;
            if (changed) begin
                state <= SETTLE;
            end else if (eval) begin
                state <= HOLD;
                if (anode_q != ANODE_BLANK) begin
                    if (bad) begin
                        seg_err <= 1'b1;
                    end else begin
                        digit       <= hex;
                        digit_idx   <= idx;
                        digit_valid <= 1'b1;
                        shadow      <= shadow_next;
                        if (frame_done) begin
                            value       <= shadow_next;
                            value_valid <= 1'b1;
                            captured    <= 8'd0;
                        end else begin
                            captured    <= captured_next;
                        end
                    end
                end
            end
        end
    end

`ifdef SEVENSEG_CAPTURE_DP_EN
    logic [7:0] shadow_dp;
    logic [7:0] shadow_dp_next;

    // dp is active-low on the bus; stored as 1 = lit.
    assign shadow_dp_next = (shadow_dp & ~idx_bit) | (cathode_q[0] ? 8'h00 : idx_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_dp <= 8'h00;
            dp_mask   <= 8'h00;
        end else if (write_en) begin
            shadow_dp <= shadow_dp_next;
            if (frame_done) dp_mask <= shadow_dp_next;
        end
    end
`else
    assign dp_mask = 8'h00;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - self-checking bench for sevenseg_capture
module tb_sevenseg_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  anode = 8'hFF;
    logic [7:0]  cathode = 8'hFF;
    logic [3:0]  digit;
    logic [2:0]  digit_idx;
    logic        digit_valid;
    logic [31:0] value;
    logic        value_valid;
    logic [7:0]  dp_mask;
    logic        seg_err;

    sevenseg_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .anode       (anode),
        .cathode     (cathode),
        .digit       (digit),
        .digit_idx   (digit_idx),
        .digit_valid (digit_valid),
        .value       (value),
        .value_valid (value_valid),
        .dp_mask     (dp_mask),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    // Lit segments per glyph, abcdefg, 1 = on.
    logic [6:0] on_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    function automatic logic [7:0] enc(input int h, input logic dp_on);
        return {~on_tab[h], ~dp_on};
    endfunction

    function automatic int dec(input logic [6:0] c);
        for (int h = 0; h < 16; h++) if (c == ~on_tab[h]) return h;
        return -1;
    endfunction

    int vectors = 0;
    int miscompares = 0;
    int dv_cnt = 0;
    int vv_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a dwell is decoded when the last S+1 samples agree
    // and the sample before them differed.
    logic [15:0] hist [$];
    bit          cap [8];
    int          nib [8];
    bit          dpb [8];
    logic [3:0]  m_digit = '0;
    logic [2:0]  m_idx = '0;
    logic        m_dv = 0, m_vv = 0, m_err = 0;
    logic [31:0] m_value = '0;
    logic [7:0]  m_dp = '0;

    task automatic model_reset();
        hist = {};
        hist.push_back(16'hFFFF);
        for (int k = 0; k < 8; k++) begin cap[k] = 0; nib[k] = 0; dpb[k] = 0; end
        m_digit = 0; m_idx = 0; m_dv = 0; m_vv = 0; m_err = 0; m_value = 0; m_dp = 0;
    endtask

    task automatic model_step();
        logic [7:0] a, c;
        bit settled, full;
        int d, ix;
        m_dv = 0; m_vv = 0; m_err = 0;
        hist.push_back({anode, cathode});
        if (hist.size() > S + 2) void'(hist.pop_front());
        settled = (hist.size() == S + 2) && (hist[0] != hist[1]);
        for (int k = 1; k < S + 2; k++) if (hist.size() == S + 2 && hist[k] != hist[S+1]) settled = 0;
        if (!settled) return;
        a = hist[S+1][15:8];
        c = hist[S+1][7:0];
        if (a == 8'hFF) return;
        d = dec(c[7:1]);
        if ($countones(~a) != 1 || d < 0) begin m_err = 1; return; end
        ix = 0;
        for (int k = 0; k < 8; k++) if (!a[k]) ix = k;
        m_dv = 1; m_digit = 4'(d); m_idx = 3'(ix);
        nib[ix] = d; dpb[ix] = !c[0]; cap[ix] = 1;
        full = 1;
        for (int k = 0; k < 8; k++) if (!cap[k]) full = 0;
        if (full) begin
            m_vv = 1;
            for (int k = 0; k < 8; k++) begin
                m_value[4*k +: 4] = 4'(nib[k]);
`ifdef SEVENSEG_CAPTURE_DP_EN
                m_dp[k] = dpb[k];
`else
                m_dp[k] = 1'b0;
`endif
                cap[k] = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("digit_valid", 32'(digit_valid), 32'(m_dv));
            chk("value_valid", 32'(value_valid), 32'(m_vv));
            chk("seg_err", 32'(seg_err), 32'(m_err));
            chk("digit", 32'(digit), 32'(m_digit));
            chk("digit_idx", 32'(digit_idx), 32'(m_idx));
            chk("value", value, m_value);
            chk("dp_mask", 32'(dp_mask), 32'(m_dp));
            if (digit_valid === 1'b1) dv_cnt++;
            if (value_valid === 1'b1) vv_cnt++;
            if (seg_err === 1'b1) err_cnt++;
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] c, input int n);
        anode = a;
        cathode = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        dv_cnt = 0; vv_cnt = 0; err_cnt = 0;
    endtask

    logic [7:0] dp_exp;
    logic [7:0] ra, rc;
    logic [6:0] r7;
    int         kind;

    initial begin
`ifdef SEVENSEG_CAPTURE_DP_EN
        dp_exp = 8'h81;
`else
        dp_exp = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", value, 32'h0);
        chk("reset_digit_valid", 32'(digit_valid), 32'h0);
        rst = 1'b1;

        // Forward frame, digit i shows i+1
        clr_cnt();
        for (int i = 0; i < 8; i++) drive(~(8'd1 << i), enc(i + 1, 1'b0), 6);
        chk("frame1_dv_count", 32'(dv_cnt), 32'd8);
        chk("frame1_vv_count", 32'(vv_cnt), 32'd1);
        chk("frame1_value", value, 32'h8765_4321);

        // Glitched dwell on digit 3, then steady A
        clr_cnt();
        drive(8'hF7, enc(2, 1'b0), 3);
        drive(8'hF7, enc(10, 1'b0), 6);
        chk("glitch_dv_count", 32'(dv_cnt), 32'd1);
        chk("glitch_digit", 32'(digit), 32'hA);
        chk("glitch_idx", 32'(digit_idx), 32'd3);
        chk("glitch_err_count", 32'(err_cnt), 32'd0);

        // Undecodable pattern
        clr_cnt();
        drive(8'hFE, 8'hFF, 6);
        chk("badseg_err_count", 32'(err_cnt), 32'd1);
        chk("badseg_dv_count", 32'(dv_cnt), 32'd0);

        // Two anodes low, then blanked
        clr_cnt();
        drive(8'hFC, enc(1, 1'b0), 6);
        chk("twohot_err_count", 32'(err_cnt), 32'd1);
        clr_cnt();
        drive(8'hFF, enc(1, 1'b0), 6);
        chk("blank_err_count", 32'(err_cnt), 32'd0);
        chk("blank_dv_count", 32'(dv_cnt), 32'd0);

        // Reverse scan with digit 5 re-shown C then D; digit i shows i+3
        clr_cnt();
        for (int i = 7; i >= 0; i--) begin
            if (i == 5) begin
                drive(~(8'd1 << i), enc(12, 1'b0), 6);
                drive(~(8'd1 << i), enc(13, 1'b0), 6);
            end else begin
                drive(~(8'd1 << i), enc(i + 3, 1'b0), 6);
            end
        end
        chk("reverse_vv_count", 32'(vv_cnt), 32'd1);
        chk("reverse_nibble5", 32'(value[23:20]), 32'hD);
        chk("reverse_value", value, 32'hA9D7_6543);

        // Reset after four digits discards the partial frame
        for (int i = 0; i < 4; i++) drive(~(8'd1 << i), enc(1, 1'b0), 6);
        rst = 1'b0;
        drive(8'hFF, 8'hFF, 3);
        chk("midreset_value", value, 32'h0);
        rst = 1'b1;
        clr_cnt();
        for (int i = 0; i < 7; i++) drive(~(8'd1 << i), enc(15 - i, (i == 0)), 6);
        chk("postreset_vv_early", 32'(vv_cnt), 32'd0);
        drive(8'h7F, enc(8, 1'b1), 6);
        chk("postreset_vv_count", 32'(vv_cnt), 32'd1);
        chk("postreset_value", value, 32'h89AB_CDEF);
        chk("postreset_dp_mask", 32'(dp_mask), 32'(dp_exp));

        // Randomised dwells
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                drive(8'hFF, 8'hFF, $urandom_range(1, 3));
                rst = 1'b1;
            end
            kind = $urandom_range(0, 99);
            ra = ~(8'd1 << $urandom_range(0, 7));
            rc = enc($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            if (kind < 7) begin
                do r7 = 7'($urandom); while (dec(r7) >= 0);
                rc = {r7, 1'($urandom_range(0, 1))};
            end else if (kind < 12) begin
                ra = 8'hFF;
            end else if (kind < 17) begin
                do ra = 8'($urandom); while ($countones(~ra) == 1 || ra == 8'hFF);
            end
            drive(ra, rc, $urandom_range(1, 10));
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
